div_iter: RTL and testbench
===========================

// Module: div_iter
// PURPOSE
//  Multi-cycle iterative divider for MIPS32 DIV/DIVU: one restoring shift-subtract step per clock.
//  Quotient goes to LO, remainder to HI.
//  Sits beside the combinational add/sub unit in the EX stage. Stalls the pipeline via busy until done.
// PARAMETERS
//  WIDTH  32  operand/result width (only 32 is verified)
//  CNT_W  6   iteration counter width; must hold WIDTH
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  start        in   1      request; accepted only in IDLE
//  sign         in   1      0 = signed (DIV), 1 = unsigned (DIVU); same encoding as the add/sub unit
//  flush        in   1      abort the in-flight op (pipeline flush/exception)
//  data_a       in   32     dividend (rs)
//  data_b       in   32     divisor (rt)
//  lo           out  32     quotient, registered
//  hi           out  32     remainder, registered
//  busy         out  1      1 from the cycle after accept until done
//  done         out  1      one-cycle pulse; hi/lo valid from this cycle on
//  div_by_zero  out  1      valid with done; tied 0 if DIV_ZERO_DETECT_EN is undefined
// BEHAVIOUR
//  Reset: state=IDLE; lo, hi, busy, done, div_by_zero all = 0; counter = 0.
//  FSM: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: start=1 at edge N:
//    - latch |a| and |b| (magnitudes only if sign=0) and the operand sign bits
//    - clear partial remainder; count=0; go to CALC
//   CALC: each edge:
//    - rem = {rem,q_msb} - divisor when non-negative, else restore
//    - shift in the quotient bit; count++
//    - after the 32nd step (edge N+32) go to FIX
//   FIX (edge N+33), signed mode only:
//    - negate quotient if the operand signs differ
//    - remainder takes the dividend's sign
//    - write lo/hi; go to DONE
//   DONE: done=1 for exactly one cycle (latency 33 clocks from the accept edge); then IDLE.
//  busy = (state != IDLE && state != DONE). start outside IDLE is ignored, never queued.
//  Back-to-back: start may be asserted in the DONE cycle; it is accepted on the following IDLE cycle.
//  lo/hi hold their last value until the next FIX/DONE write. They are never modified mid-operation.
//  Arithmetic:
//   - 33-bit partial remainder, to catch the sign of the trial subtraction
//   - signed 0x80000000 / 0xFFFFFFFF wraps: lo=0x80000000, hi=0; no trap
//  flush=1 in any state: next state IDLE; busy=0, done=0; lo/hi unchanged. flush beats start.
//  rst_n low mid-operation: immediate async return to reset values.
// CONFIGURATION
//  DIV_ZERO_DETECT_EN defined:
//   - divisor==0 at accept goes straight to DONE at edge N+1
//   - lo=0xFFFFFFFF, hi=data_a, div_by_zero=1 with done
//  Undefined:
//   - zero divisor runs the full 33 cycles
//   - result is whatever the algorithm produces (unsigned: lo=0xFFFFFFFF, hi=dividend)
//   - div_by_zero is constant 0
// STRUCTURE
//  Shared header mips32_defs.vh:
//   - FSM state localparams (DIV_IDLE/CALC/FIX/DONE, 2 bits)
//   - WORD_W=32
//   - SIGNED_OP=1'b0 / UNSIGNED_OP=1'b1 encodings, shared with the add/sub unit
//  Sub-module div_step: combinational single restoring step.
//   - (rem_in[32:0], dvd_msb, divisor[31:0]) -> (rem_out, q_bit)
//   - instantiated once in CALC
// TESTING
//  1. sign=0, a=100, b=7 -> done 33 clk after accept; lo=14, hi=2, busy high cycles 1..32
//  2. sign=0, a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF
//  3. sign=1, a=0xFFFFFFFF, b=0x10 -> lo=0x0FFFFFFF, hi=0xF; signed, a=0x80000000, b=-1 -> lo=0x80000000, hi=0
//  4. b=0, a=0x1234 -> with _EN: done at +1, lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1; without: done at +33, flag 0
//  5. start re-asserted at cycle 10 of an op -> ignored, first result unchanged; start in DONE cycle -> next op accepted
//  6. flush at cycle 15 -> IDLE next cycle, no done, lo/hi keep old; rst_n low at cycle 20 -> all outputs 0 immediately

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared constants, operation encodings and FSM state type for the iterative MIPS32 divider.
package div_iter_pkg;

    localparam int WORD_W    = 32;
    localparam int DIV_CNT_W = 6;

    // Same sign-select encoding as the neighbouring add/sub unit.
    localparam logic SIGNED_OP   = 1'b0;
    localparam logic UNSIGNED_OP = 1'b1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } divState_e;

    function automatic logic [WORD_W-1:0] absVal(input logic [WORD_W-1:0] value,
                                                 input logic              isSigned);
        absVal = (isSigned && value[WORD_W-1]) ? -value : value;
    endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/result bundle between the EX stage and the iterative divider.
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             sign;
    logic             flush;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, sign, flush, data_a, data_b,
        input  lo, hi, busy, done, div_by_zero
    );

    modport slave (
        input  start, sign, flush, data_a, data_b,
        output lo, hi, busy, done, div_by_zero
    );
endinterface

// File: rtl/div_iter_step.sv
// One combinational restoring shift-subtract step of the divider.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             dvdMsb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             qBit_o
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // One guard bit above the remainder so the trial subtraction's sign is always visible.
    always_comb begin
        shifted = {rem_i, dvdMsb_i};
        trial   = shifted - {2'b00, divisor_i};
        qBit_o  = ~trial[WIDTH+1];
        rem_o   = qBit_o ? trial[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider for MIPS32 DIV/DIVU (quotient -> lo, remainder -> hi).
// Optional early divide-by-zero exit when DIV_ZERO_DETECT_EN is defined.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic      clk,
    input  logic      rst_n,
    div_iter_if.slave bus
);

    divState_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH:0]   partRem_q, partRem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic             negQuot_q, negQuot_d;
    logic             negRem_q, negRem_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH:0]   stepRem;
    logic             stepBit;
    logic             isSigned;

`ifdef DIV_ZERO_DETECT_EN
    logic [WIDTH-1:0] rawA_q, rawA_d;
    logic             divZero_q, divZero_d;
`endif

    assign isSigned = (bus.sign == SIGNED_OP);

    // The dividend shifts out of quot_q MSB-first while quotient bits shift in at the LSB.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (partRem_q),
        .dvdMsb_i  (quot_q[WIDTH-1]),
        .divisor_i (divisor_q),
        .rem_o     (stepRem),
        .qBit_o    (stepBit)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        partRem_d = partRem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        negQuot_d = negQuot_q;
        negRem_d  = negRem_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
`ifdef DIV_ZERO_DETECT_EN
        rawA_d    = rawA_q;
        divZero_d = divZero_q;
`endif
        if (bus.flush) begin
            state_d = DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (bus.start) begin
                        quot_d    = absVal(bus.data_a, isSigned);
                        divisor_d = absVal(bus.data_b, isSigned);
                        negQuot_d = isSigned & (bus.data_a[WIDTH-1] ^ bus.data_b[WIDTH-1]);
                        negRem_d  = isSigned & bus.data_a[WIDTH-1];
                        partRem_d = '0;
                        count_d   = '0;
`ifdef DIV_ZERO_DETECT_EN
                        rawA_d    = bus.data_a;
`endif
                        state_d   = DIV_CALC;
                    end
                end
                DIV_CALC: begin
                    partRem_d = stepRem;
                    quot_d    = {quot_q[WIDTH-2:0], stepBit};
                    count_d   = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DIV_FIX;
                    end
`ifdef DIV_ZERO_DETECT_EN
                    if (divisor_q == '0) begin
                        lo_d      = '1;
                        hi_d      = rawA_q;
                        divZero_d = 1'b1;
                        state_d   = DIV_DONE;
                    end
`endif
                end
                DIV_FIX: begin
                    lo_d    = negQuot_q ? -quot_q : quot_q;
                    hi_d    = negRem_q ? -partRem_q[WIDTH-1:0] : partRem_q[WIDTH-1:0];
`ifdef DIV_ZERO_DETECT_EN
                    divZero_d = 1'b0;
`endif
                    state_d = DIV_DONE;
                end
                DIV_DONE: begin
                    state_d = DIV_IDLE;
                end
                default: begin
                    state_d = DIV_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DIV_IDLE;
            count_q   <= '0;
            partRem_q <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
`ifdef DIV_ZERO_DETECT_EN
            rawA_q    <= '0;
            divZero_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            partRem_q <= partRem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
`ifdef DIV_ZERO_DETECT_EN
            rawA_q    <= rawA_d;
            divZero_q <= divZero_d;
`endif
        end
    end

    assign bus.lo   = lo_q;
    assign bus.hi   = hi_q;
    assign bus.busy = (state_q == DIV_CALC) || (state_q == DIV_FIX);
    assign bus.done = (state_q == DIV_DONE);
`ifdef DIV_ZERO_DETECT_EN
    assign bus.div_by_zero = divZero_q;
`else
    assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: expected results are queued at issue and popped on done.
module tb_div_iter;
    import div_iter_pkg::*;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
    } expRes_t;

`ifdef DIV_ZERO_DETECT_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif
    localparam int ZERO_LAT = ZERO_EN ? 1 : 33;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    div_iter_if #(.WIDTH(32)) bus ();

    div_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    expRes_t     sb[$];
    expRes_t     monExp;
    int          nVectors  = 0;
    int          nMiss     = 0;
    int          doneCount = 0;
    int          doneBefore;
    logic [31:0] lastLo = 32'd0;
    logic [31:0] lastHi = 32'd0;
    logic [31:0] rndA, rndB;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiss++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference: native SV division, with the two cases it cannot express handled explicitly.
    function automatic expRes_t model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        expRes_t r;
        logic    isS;
        isS   = (sgn == SIGNED_OP);
        r.dbz = 1'b0;
        if (b == 32'd0) begin
            if (ZERO_EN) begin
                r.lo  = 32'hFFFF_FFFF;
                r.hi  = a;
                r.dbz = 1'b1;
            end else begin
                r.lo = (isS && a[31]) ? 32'd1 : 32'hFFFF_FFFF;
                r.hi = a;
            end
        end else if (!isS) begin
            r.lo = a / b;
            r.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r.lo = 32'h8000_0000;
            r.hi = 32'd0;
        end else begin
            r.lo = $signed(a) / $signed(b);
            r.hi = $signed(a) % $signed(b);
        end
        return r;
    endfunction

    task automatic driveOp(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        bus.data_a = a;
        bus.data_b = b;
        bus.sign   = sgn;
        bus.start  = 1'b1;
        sb.push_back(model(a, b, sgn));
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        @(negedge clk);
        driveOp(a, b, sgn);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input int expLat, input int elapsed);
        int cyc  = elapsed;
        bit seen = 1'b0;
        checkOutput("busyAfterAccept", 32'(bus.busy), 32'd1);
        while (!seen && cyc < elapsed + 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done) seen = 1'b1;
            else if (cyc == expLat - 1) checkOutput("busyBeforeDone", 32'(bus.busy), 32'd1);
        end
        if (!seen) begin
            checkOutput("doneTimeout", 32'(bus.done), 32'd1);
        end else begin
            checkOutput("latency", 32'(cyc), 32'(expLat));
            checkOutput("busyAtDone", 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic finishOp();
        @(posedge clk);
        #1;
        checkOutput("donePulse", 32'(bus.done), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            doneCount++;
            if (sb.size() == 0) begin
                checkOutput("spuriousDone", 32'(bus.done), 32'd0);
            end else begin
                monExp = sb.pop_front();
                checkOutput("lo", bus.lo, monExp.lo);
                checkOutput("hi", bus.hi, monExp.hi);
                checkOutput("divByZero", 32'(bus.div_by_zero), 32'(monExp.dbz));
                lastLo = monExp.lo;
                lastHi = monExp.hi;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.sign   = SIGNED_OP;
        bus.flush  = 1'b0;
        bus.data_a = 32'd0;
        bus.data_b = 32'd0;
        #12;
        checkOutput("rstLo", bus.lo, 32'd0);
        checkOutput("rstHi", bus.hi, 32'd0);
        checkOutput("rstBusy", 32'(bus.busy), 32'd0);
        checkOutput("rstDone", 32'(bus.done), 32'd0);
        checkOutput("rstDbz", 32'(bus.div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'd100, 32'd7, SIGNED_OP);
        waitDone(33, 0);
        finishOp();
        applyStimulus(32'hFFFF_FFF9, 32'd2, SIGNED_OP);
        waitDone(33, 0);
        finishOp();
        applyStimulus(32'hFFFF_FFFF, 32'h10, UNSIGNED_OP);
        waitDone(33, 0);
        finishOp();
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, SIGNED_OP);
        waitDone(33, 0);
        finishOp();
        applyStimulus(32'h1234, 32'd0, UNSIGNED_OP);
        waitDone(ZERO_LAT, 0);
        finishOp();

        for (int i = 0; i < 6; i++) begin
            rndA = $urandom;
            rndB = $urandom >> (i * 4);
            if (rndB == 32'd0) rndB = 32'd3;
            applyStimulus(rndA, rndB, (i % 2 == 0) ? SIGNED_OP : UNSIGNED_OP);
            waitDone(33, 0);
            finishOp();
        end

        // A second start ten cycles into an operation must be dropped, not queued.
        applyStimulus(32'd1000, 32'd3, UNSIGNED_OP);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.data_a = 32'd55;
        bus.data_b = 32'd5;
        bus.start  = 1'b1;
        checkOutput("loHeldMidOp", bus.lo, lastLo);
        checkOutput("hiHeldMidOp", bus.hi, lastHi);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(33, 10);
        finishOp();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("idleAfterIgnoredStart", 32'(bus.busy), 32'd0);

        // Start raised during the done cycle is taken on the following idle cycle.
        applyStimulus(32'hDEAD_BEEF, 32'h1234, UNSIGNED_OP);
        waitDone(33, 0);
        driveOp(32'hFFFF_0000, 32'hFFFF_FFF0, SIGNED_OP);
        @(posedge clk);
        #1;
        checkOutput("b2bIdleGapBusy", 32'(bus.busy), 32'd0);
        checkOutput("b2bIdleGapDone", 32'(bus.done), 32'd0);
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        waitDone(33, 0);
        finishOp();

        applyStimulus(32'd77777, 32'd9, UNSIGNED_OP);
        doneBefore = doneCount;
        repeat (14) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flushBusy", 32'(bus.busy), 32'd0);
        checkOutput("flushDone", 32'(bus.done), 32'd0);
        checkOutput("flushLoHeld", bus.lo, lastLo);
        checkOutput("flushHiHeld", bus.hi, lastHi);
        void'(sb.pop_back());
        @(negedge clk);
        bus.start  = 1'b1;
        bus.data_a = 32'd10;
        bus.data_b = 32'd2;
        @(posedge clk);
        #1;
        checkOutput("flushBeatsStart", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("noDoneAfterFlush", 32'(doneCount), 32'(doneBefore));

        applyStimulus(32'h00AB_CDEF, 32'd13, UNSIGNED_OP);
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midRstLo", bus.lo, 32'd0);
        checkOutput("midRstHi", bus.hi, 32'd0);
        checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
        checkOutput("midRstDone", 32'(bus.done), 32'd0);
        checkOutput("midRstDbz", 32'(bus.div_by_zero), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(32'hFFFF_FF00, 32'd7, SIGNED_OP);
        waitDone(33, 0);
        finishOp();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

endmodule
